// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types, default sizing and the address fault check for the
//            data-memory responder and its storage array.
// Contents : state_t      - responder FSM state encoding (IDLE/WAIT/RESP)
//            DEF_*        - default DATA_WIDTH / ADDR_BITS / WAIT_CYCLES
//            addr_fault() - 1 when a byte address is misaligned or beyond
//                           the implemented word range
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_BITS   = 4;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Any nonzero bit above the word-index field means the address lies outside
  // the array; flagging it avoids silently aliasing onto a low word.
  function automatic logic addr_fault(input logic [31:0] addr, input int addr_bits);
    logic [31:0] w_high;
    w_high = addr >> (addr_bits + 2);
    return (addr[1:0] != 2'b00) || (w_high != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_ram
// Purpose  : Word-addressed storage array with one write port and a
//            synchronous read; cleared to zero by the asynchronous reset.
// Ports    : clk   - clock, all state on the rising edge
//            reset - asynchronous active-low clear of array and read data
//            en    - perform an access at this edge
//            we    - 1 = write wdata, 0 = read into rdata
//            addr  - word index
//            wdata - write data
//            rdata - registered read data (0 after a write)
// Revision : 1.0 - initial release
// ============================================================================
module data_ram
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int C_DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
        r_rdata     <= '0;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory responder for the MEM stage. Accepts one request at
//            a time over a valid/ready handshake, waits a programmable number
//            of cycles, performs the access on data_ram and holds a response
//            (read data + fault flag) until the initiator takes it.
// Ports    : clk        - clock
//            reset      - asynchronous active-low reset
//            req_valid  - request present          req_ready  - can accept
//            req_write  - 1 = store, 0 = load      req_addr   - byte address
//            req_wdata  - store data
//            resp_valid - response present         resp_ready - response taken
//            resp_rdata - load data (0 for stores and faults)
//            resp_err   - misaligned or out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  // The access is always made from the latched request, so zero wait states
  // still spend one cycle in WAIT; this keeps req_* off every output path.
  localparam int         C_WAIT_EFF  = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam logic [3:0] C_WAIT_LOAD = C_WAIT_EFF[3:0];

  state_t                r_state;
  logic [3:0]            r_count;
  logic                  r_write;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_access;
  logic                  w_fault;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_access = (r_state == ST_WAIT) && (r_count == 4'd1);
  assign w_fault  = addr_fault(r_addr, ADDR_BITS);

  // A faulting access never reaches the array, so its contents stay intact.
  data_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) data_memory (
    .clk   (clk),
    .reset (reset),
    .en    (w_access && !w_fault),
    .we    (r_write),
    .addr  (r_addr[ADDR_BITS+1:2]),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_count <= C_WAIT_LOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_count <= r_count - 4'd1;
          if (w_access) begin
            r_err   <= w_fault;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_err   = r_err;
  // The array's read register only updates on a real access, so a fault
  // masks whatever it still holds from an earlier transaction.
  assign resp_rdata = r_err ? '0 : w_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder. A main instance with
//            two wait states is driven through reset, store/load, faults,
//            backpressure and back-to-back traffic against a scoreboard; three
//            extra instances (0, 1 and 5 wait states) cover the latency sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [16];
  logic [31:0] snap  [16];
  bit          seen;

  data_mem_responder #(
    .DATA_WIDTH (32),
    .ADDR_BITS  (4),
    .WAIT_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Latency sweep instances: index 0 -> 0 waits, 1 -> 1 wait, 2 -> 5 waits.
  logic        sw_valid  [3];
  logic        sw_write  [3];
  logic [31:0] sw_addr   [3];
  logic [31:0] sw_wdata  [3];
  logic        sw_ready  [3];
  logic        sw_rvalid [3];
  logic [31:0] sw_rdata  [3];
  logic        sw_err    [3];

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    data_mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_BITS  (4),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 5))
    ) u_sw (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (sw_valid[g]),
      .req_ready  (sw_ready[g]),
      .req_write  (sw_write[g]),
      .req_addr   (sw_addr[g]),
      .req_wdata  (sw_wdata[g]),
      .resp_valid (sw_rvalid[g]),
      .resp_ready (1'b1),
      .resp_rdata (sw_rdata[g]),
      .resp_err   (sw_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard consumer: latency on the first response cycle, data/err on the
  // handshake cycle.
  always @(negedge clk) begin
    if (!reset) begin
      seen = 1'b0;
    end else if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_resp", {63'd0, resp_valid}, 64'd0);
      end else begin
        if (!seen) begin
          check("latency", 64'(cyc - sb_q[0].acc), 64'(LAT));
          seen = 1'b1;
        end
        if (resp_ready) begin
          check("rdata", {32'd0, resp_rdata}, {32'd0, sb_q[0].rdata});
          check("err", {63'd0, resp_err}, {63'd0, sb_q[0].err});
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit push, output int acc);
    int   n;
    bit   flt;
    exp_t e;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      flt     = (a[1:0] != 2'b00) || (a[31:6] != 26'd0);
      e.rdata = (flt || wr) ? 32'd0 : model[a[5:2]];
      e.err   = flt;
      e.acc   = acc;
      if (!flt && wr) model[a[5:2]] = d;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic sweep_txn(input int i, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input int lat, input logic [31:0] exp);
    int n;
    int acc;
    sw_write[i] = wr;
    sw_addr[i]  = a;
    sw_wdata[i] = d;
    sw_valid[i] = 1'b1;
    n = 0;
    while (!sw_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    sw_valid[i] = 1'b0;
    n = 0;
    while (!sw_rvalid[i] && n < 50) begin
      @(negedge clk);
      n++;
      if (!sw_rvalid[i]) check($sformatf("sw%0d_ready_wait", i), {63'd0, sw_ready[i]}, 64'd0);
    end
    check($sformatf("sw%0d_latency", i), 64'(cyc - acc), 64'(lat));
    check($sformatf("sw%0d_rdata", i), {32'd0, sw_rdata[i]}, {32'd0, exp});
    check($sformatf("sw%0d_err", i), {63'd0, sw_err[i]}, 64'd0);
    check($sformatf("sw%0d_ready_resp", i), {63'd0, sw_ready[i]}, 64'd0);
    @(negedge clk);
    check($sformatf("sw%0d_ready_after", i), {63'd0, sw_ready[i]}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int accs [4];
    int diffs;

    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      sw_valid[i] = 1'b0;
      sw_write[i] = 1'b0;
      sw_addr[i]  = 32'd0;
      sw_wdata[i] = 32'd0;
    end
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    reset      = 1'b1;
    #1 reset   = 1'b0;
    #2;
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Reset in the middle of a store's wait period.
    do_txn(1'b1, 32'h8, 32'hDEADBEEF, 1'b0, acc);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_resp_err", {63'd0, resp_err}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_mem_word2", {32'd0, dut.data_memory.r_mem[2]}, 64'd0);
    do_txn(1'b0, 32'h8, 32'd0, 1'b1, acc);
    req_valid = 1'b0;
    drain();

    // Store then load.
    do_txn(1'b1, 32'h4, 32'h12345678, 1'b1, acc);
    do_txn(1'b0, 32'h4, 32'd0, 1'b1, acc);
    req_valid = 1'b0;
    drain();

    // Faults.
    do_txn(1'b0, 32'h6, 32'd0, 1'b1, acc);
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) snap[i] = dut.data_memory.r_mem[i];
    do_txn(1'b1, 32'h40, 32'h55555555, 1'b1, acc);
    req_valid = 1'b0;
    drain();
    diffs = 0;
    for (int i = 0; i < 16; i++) if (dut.data_memory.r_mem[i] !== snap[i]) diffs++;
    check("fault_store_untouched", 64'(diffs), 64'd0);
    do_txn(1'b0, 32'h3C, 32'd0, 1'b1, acc);
    req_valid = 1'b0;
    drain();

    // Backpressure.
    do_txn(1'b1, 32'h14, 32'hA5A5A5A5, 1'b1, acc);
    req_valid = 1'b0;
    drain();
    resp_ready = 1'b0;
    do_txn(1'b0, 32'h14, 32'd0, 1'b1, acc);
    req_valid = 1'b0;
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rdata", {32'd0, resp_rdata}, 64'hA5A5A5A5);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      if (i == 1) begin
        req_write = 1'b1;
        req_addr  = 32'h18;
        req_wdata = 32'hFFFFFFFF;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
    end
    resp_ready = 1'b1;
    drain();
    repeat (4) @(negedge clk);
    check("bp_ignored_store", {32'd0, dut.data_memory.r_mem[6]}, 64'd0);

    // Back-to-back loads with req_valid held high.
    do_txn(1'b1, 32'h0, 32'h11111111, 1'b1, acc);
    do_txn(1'b1, 32'hC, 32'hCCCC0000, 1'b1, acc);
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) do_txn(1'b0, 32'(i * 4), 32'd0, 1'b1, accs[i]);
    req_valid = 1'b0;
    drain();
    for (int i = 1; i < 4; i++) check("b2b_interval", 64'(accs[i] - accs[i-1]), 64'(LAT + 2));

    // Latency sweep on the extra instances.
    for (int i = 0; i < 3; i++) begin
      sweep_txn(i, 1'b1, 32'h4, 32'h77000000 + 32'(i), (i == 2) ? 5 : 1, 32'd0);
      sweep_txn(i, 1'b0, 32'h4, 32'd0, (i == 2) ? 5 : 1, 32'h77000000 + 32'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
